fir_decim_fifo: RTL
===================

# fir_decim_fifo

Decimating output stage directly downstream of the 51-tap FIR low-pass filter. It integrates-and-dumps blocks of 2^LOG2_DECIM filtered samples and stores each block average in a small first-word-fall-through FIFO. A downstream consumer drains that FIFO over a valid/ready handshake. Overflow is reported with a sticky flag.

## Interface

Parameters:
- WIDTH, 16: sample width, signed two's complement.
- LOG2_DECIM, 2: decimation factor is 2^LOG2_DECIM; legal range 0..5.
- LOG2_DEPTH, 2: FIFO depth is 2^LOG2_DEPTH entries; legal range 1..6.

Ports:
- clk  in  1  rising-edge clock for all state.
- reset  in  1  asynchronous, active-low; clears all state while low.
- din  in  WIDTH  signed filtered sample from the FIR output.
- din_valid  in  1  din is a new sample this cycle; one strobe per filter output.
- dout  out  WIDTH  signed decimated sample at the FIFO head; 0 when empty.
- dout_valid  out  1  FIFO not empty.
- dout_ready  in  1  consumer accepts dout this cycle.
- level  out  LOG2_DEPTH+1  current FIFO occupancy, 0..2^LOG2_DEPTH.
- overflow  out  1  sticky; a decimated sample was dropped.
- clear_ovf  in  1  synchronous clear of overflow.

## Operation

- Phase counter, LOG2_DECIM bits:
  - Advances only on cycles where din_valid is high.
  - Wraps from 2^LOG2_DECIM-1 to 0.
  - Gaps in din_valid of any length are allowed and do not affect block boundaries.
- Accumulator, WIDTH+LOG2_DECIM bits, signed.
  - On din_valid with phase != last: acc <= acc + sign-extended din.
  - On din_valid with phase == last: sum = acc + din, computed combinationally.
    - Push request with value sum >>> LOG2_DECIM (arithmetic shift, truncation toward negative infinity).
    - acc <= 0.
  - The result always fits in WIDTH; no saturation is required.
  - LOG2_DECIM=0: every din_valid pushes din unchanged.
- FIFO, first-word fall-through:
  - dout is the head entry, combinational from storage.
  - Pop occurs when dout_valid && dout_ready.
  - A push is accepted when level < depth, or when a pop occurs in the same cycle.
  - When full with no pop, the new sample is dropped and overflow <= 1. The FIFO contents, phase and accumulator continue normally.
  - Simultaneous push and pop: level is unchanged and ordering is preserved.
  - Read and write pointers are LOG2_DEPTH bits and wrap naturally.
- overflow:
  - Set by a dropped push.
  - Cleared by clear_ovf.
  - If a drop and clear_ovf occur in the same cycle, the set wins.
- Reset low, at any time including mid-block: phase=0, acc=0, FIFO empty, dout=0, dout_valid=0, level=0, overflow=0. The first din_valid after release starts a new block.

## Timing

- Latency: the clock edge that captures the last din_valid of a block writes the FIFO. If the FIFO was empty, dout and dout_valid are valid in the very next cycle (1-cycle latency).
- Throughput: one pop per cycle. One push per cycle, possible when LOG2_DECIM=0.
- level and dout_valid update on the same edge as the push or pop that changes them.
- overflow asserts on the edge of the dropped push.
- All outputs are registered or derived from registers. No combinational path runs from din or din_valid to any output. The only input-to-output combinational path is dout_ready -> none; dout_ready affects state only.
- Reset deassertion is expected synchronous to clk externally; the block does not resynchronise it.

## Test plan

All scenarios use LOG2_DECIM=2 and LOG2_DEPTH=2 unless noted.

- Basic average: dout_ready=1; din=100,200,300,400 with din_valid on 4 consecutive cycles -> dout=250, dout_valid high for exactly 1 cycle, starting the cycle after the 4th strobe; level returns to 0.
- Negative rounding: din=-1,-1,-1,-2 -> dout=-2 (sum -5 >>> 2). Then din=0x7FFF four times -> dout=0x7FFF. Then 0x8000 four times -> dout=0x8000 (no wrap).
- Sparse valid: din_valid high every 3rd cycle, din=4,8,12,16 -> single output 10, appearing 1 cycle after the 4th strobe; idle cycles do not advance the phase.
- Overflow: dout_ready=0; five blocks producing averages 1..5 -> level=4, 5th dropped, overflow=1. Then dout_ready=1 -> outputs 1,2,3,4 on consecutive cycles, level 0, overflow still 1. clear_ovf pulse -> overflow=0. A clear_ovf coinciding with another drop -> overflow stays 1.
- Full with simultaneous pop and push: level=4 holding 1,2,3,4; dout_ready=1 on the cycle a block of value 9 completes -> level stays 4, overflow stays 0, drain order 2,3,4,9.
- Async reset mid-block: after 2 samples (10,20), pulse reset low between clock edges -> dout_valid, level and dout go to 0 immediately. The next four samples 1,2,3,6 yield dout=3 (fresh block, no residue from 10,20).

Source files
------------

// File: rtl/fir_decim_fifo.sv
// fir_decim_fifo
//   Decimating output stage behind the FIR low-pass filter. It sums blocks of
//   2^LOG2_DECIM filtered samples and divides each sum by the block length with
//   an arithmetic shift, which rounds toward negative infinity. Each block
//   average is written into a first-word-fall-through FIFO. A consumer drains
//   the FIFO over a valid/ready handshake. A sample that arrives while the FIFO
//   is full and not popping is dropped, and the sticky overflow flag is set.
//
// Ports
//   clk         rising-edge clock for all state
//   reset       asynchronous active-low reset; clears all state
//   din         signed filtered sample
//   din_valid   din carries a new sample this cycle
//   dout        signed FIFO head entry; 0 when the FIFO is empty
//   dout_valid  FIFO not empty
//   dout_ready  consumer accepts dout this cycle
//   level       FIFO occupancy, 0..2^LOG2_DEPTH
//   overflow    sticky flag; a decimated sample was dropped
//   clear_ovf   synchronous clear of overflow (a drop in the same cycle wins)
module fir_decim_fifo #(
  parameter int WIDTH      = 16,
  parameter int LOG2_DECIM = 2,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] din,
  input  logic                    din_valid,
  output logic signed [WIDTH-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [LOG2_DEPTH:0]     level,
  output logic                    overflow,
  input  logic                    clear_ovf
);

  localparam int AW    = WIDTH + LOG2_DECIM;
  // The phase register keeps at least one bit so that LOG2_DECIM=0 stays legal.
  // In that case every sample counts as the last one, and the phase never moves.
  localparam int PW    = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic        [PW-1:0]         phase;
  logic signed [AW-1:0]         acc;
  logic signed [AW-1:0]         sum;
  logic                         last_phase;
  logic                         push;
  logic signed [WIDTH-1:0]      push_data;

  logic signed [WIDTH-1:0]      mem [DEPTH];
  logic        [LOG2_DEPTH-1:0] wptr;
  logic        [LOG2_DEPTH-1:0] rptr;
  logic                         pop;
  logic                         full;
  logic                         write;
  logic                         drop;

  assign last_phase = (LOG2_DECIM == 0) || (phase == PW'((1 << LOG2_DECIM) - 1));
  assign sum        = acc + AW'(din);
  assign push       = din_valid && last_phase;
  assign push_data  = WIDTH'(sum >>> LOG2_DECIM);

  assign dout_valid = (level != '0);
  assign dout       = dout_valid ? mem[rptr] : '0;
  assign pop        = dout_valid && dout_ready;
  assign full       = (level == (LOG2_DEPTH + 1)'(DEPTH));
  // When the FIFO is full and a pop happens in the same cycle, wptr equals rptr.
  // The write reuses the slot that is being consumed on this edge.
  assign write      = push && (!full || pop);
  assign drop       = push && full && !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
      acc   <= '0;
    end else if (din_valid) begin
      if (last_phase) begin
        phase <= '0;
        acc   <= '0;
      end else begin
        phase <= phase + PW'(1);
        acc   <= sum;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write) begin
      mem[wptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (write) wptr <= wptr + LOG2_DEPTH'(1);
      if (pop)   rptr <= rptr + LOG2_DEPTH'(1);
      case ({write, pop})
        2'b10:   level <= level + (LOG2_DEPTH + 1)'(1);
        2'b01:   level <= level - (LOG2_DEPTH + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule
